// File: rtl/sprite_update_arbiter.sv
// Round-robin arbiter that shares one sprite renderer among several game-logic requesters.
// Each granted update is held in a shadow register and committed only on vblank, so no frame tears.
module sprite_update_arbiter #(
    parameter int N_REQ  = 4,
    parameter int POS_W  = 5,
    parameter int ICON_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      vblank,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*POS_W-1:0]    req_x,
    input  logic [N_REQ*POS_W-1:0]    req_y,
    input  logic [N_REQ*ICON_W-1:0]   req_icon,
    output logic [N_REQ-1:0]          grant,
    output logic [POS_W-1:0]          pos_x,
    output logic [POS_W-1:0]          pos_y,
    output logic [ICON_W-1:0]         icon,
    output logic [2:0]                owner,
    output logic                      pending,
    output logic                      commit,
    output logic [CNT_W-1:0]          frame_count
);

    typedef enum logic {IDLE, WAIT_VB} state_t;

    state_t state, state_nx;

    logic [2:0]        last_grant;
    logic [2:0]        sel;
    logic              sel_vld;
    logic              take;
    logic              do_commit;
    logic [N_REQ-1:0]  grant_nx;
    logic [POS_W-1:0]  cand_x, cand_y;
    logic [ICON_W-1:0] cand_icon;

    logic [POS_W-1:0]  sh_x, sh_y;
    logic [ICON_W-1:0] sh_icon;
    logic [2:0]        sh_owner;

    // Scan from the requester after the last winner, wrapping modulo N_REQ.
    always_comb begin : scan
        logic [3:0] idx;
        sel     = last_grant;
        sel_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, last_grant} + 4'(k);
            if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
            for (int i = 0; i < N_REQ; i++) begin
                if (!sel_vld && idx == 4'(i) && req[i]) begin
                    sel_vld = 1'b1;
                    sel     = 3'(i);
                end
            end
        end
    end

    always_comb begin
        cand_x    = '0;
        cand_y    = '0;
        cand_icon = '0;
        grant_nx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == 3'(i)) begin
                cand_x    = req_x[i*POS_W +: POS_W];
                cand_y    = req_y[i*POS_W +: POS_W];
                cand_icon = req_icon[i*ICON_W +: ICON_W];
                grant_nx[i] = take;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A vblank seen while still IDLE never commits the grant taken on the same edge.
    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        do_commit = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_vld) begin
                    take     = 1'b1;
                    state_nx = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    do_commit = 1'b1;
                    state_nx  = IDLE;
                end
            end
        endcase
    end

    assign pending = (state == WAIT_VB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            commit      <= 1'b0;
            last_grant  <= 3'(N_REQ - 1);
            sh_x        <= '0;
            sh_y        <= '0;
            sh_icon     <= '0;
            sh_owner    <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            icon        <= '0;
            owner       <= '0;
            frame_count <= '0;
        end else begin
            grant  <= grant_nx;
            commit <= do_commit;
            if (take) begin
                last_grant <= sel;
                sh_x       <= cand_x;
                sh_y       <= cand_y;
                sh_icon    <= cand_icon;
                sh_owner   <= sel;
            end
            if (do_commit) begin
                pos_x <= sh_x;
                pos_y <= sh_y;
                icon  <= sh_icon;
                owner <= sh_owner;
            end
            if (vblank) frame_count <= frame_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sprite_update_arbiter.sv
// Directed bench for sprite_update_arbiter: grant order, vblank commit timing,
// sampling point, mid-frame reset and frame counter wrap (CNT_W=4).
module tb_sprite_update_arbiter;

    localparam int N = 4;
    localparam int PW = 5;
    localparam int IW = 1;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          vblank;
    logic [N-1:0]  req;
    logic [PW-1:0] xs [N];
    logic [PW-1:0] ys [N];
    logic [IW-1:0] ics [N];
    logic [N*PW-1:0] req_x, req_y;
    logic [N*IW-1:0] req_icon;
    logic [N-1:0]  grant;
    logic [PW-1:0] pos_x, pos_y;
    logic [IW-1:0] icon;
    logic [2:0]    owner;
    logic          pending, commit;
    logic [CW-1:0] frame_count;

    int n_chk = 0;
    int n_pass = 0;

    assign req_x    = {xs[3], xs[2], xs[1], xs[0]};
    assign req_y    = {ys[3], ys[2], ys[1], ys[0]};
    assign req_icon = {ics[3], ics[2], ics[1], ics[0]};

    sprite_update_arbiter #(
        .N_REQ(N), .POS_W(PW), .ICON_W(IW), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .vblank(vblank), .req(req),
        .req_x(req_x), .req_y(req_y), .req_icon(req_icon),
        .grant(grant), .pos_x(pos_x), .pos_y(pos_y), .icon(icon),
        .owner(owner), .pending(pending), .commit(commit),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic vb_cycle();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        vblank = 1'b0;
        req    = '0;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0; ys[i] = '0; ics[i] = '0;
        end
        #2;
        do_reset();

        // reset state
        check("rst_grant", 32'(grant), 0);
        check("rst_pos_x", 32'(pos_x), 0);
        check("rst_pos_y", 32'(pos_y), 0);
        check("rst_icon", 32'(icon), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_commit", 32'(commit), 0);
        check("rst_fc", 32'(frame_count), 0);

        // 1: single request then vblank
        req = 4'b0001; xs[0] = 5'd3; ys[0] = 5'd7; ics[0] = 1'b1;
        tick();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_pending", 32'(pending), 1);
        req = '0;
        tick();
        check("t1_grant_pulse", 32'(grant), 0);
        check("t1_pos_hold", 32'(pos_x), 0);
        vb_cycle();
        check("t1_commit", 32'(commit), 1);
        check("t1_pos_x", 32'(pos_x), 3);
        check("t1_pos_y", 32'(pos_y), 7);
        check("t1_icon", 32'(icon), 1);
        check("t1_owner", 32'(owner), 0);
        check("t1_pending", 32'(pending), 0);
        check("t1_fc", 32'(frame_count), 1);
        tick();
        check("t1_commit_pulse", 32'(commit), 0);

        // 2: all requesting over 8 frames
        do_reset();
        for (int i = 0; i < N; i++) begin
            xs[i] = 5'(i * 3 + 2); ys[i] = 5'(30 - i); ics[i] = 1'(i);
        end
        req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            tick();
            check("t2_grant", 32'(grant), 32'(1 << (f % 4)));
            check("t2_no_commit", 32'(commit), 0);
            vb_cycle();
            check("t2_commit", 32'(commit), 1);
            check("t2_grant_off", 32'(grant), 0);
            check("t2_owner", 32'(owner), 32'(f % 4));
            check("t2_pos_x", 32'(pos_x), 32'((f % 4) * 3 + 2));
            check("t2_pos_y", 32'(pos_y), 32'(30 - (f % 4)));
        end
        req = '0;
        tick();

        // 3: grant and vblank on the same edge in IDLE
        req = 4'b0010; xs[1] = 5'd17;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        req = '0;
        check("t3_grant", 32'(grant), 32'b0010);
        check("t3_no_commit", 32'(commit), 0);
        check("t3_pending", 32'(pending), 1);
        tick();
        tick();
        check("t3_still_pending", 32'(pending), 1);
        check("t3_still_no_commit", 32'(commit), 0);
        vb_cycle();
        check("t3_commit", 32'(commit), 1);
        check("t3_owner", 32'(owner), 1);
        check("t3_pos_x", 32'(pos_x), 17);

        // 4: data changes after grant are ignored
        tick();
        req = 4'b0100; xs[2] = 5'd9;
        tick();
        check("t4_grant", 32'(grant), 32'b0100);
        req = '0; xs[2] = 5'd20;
        tick();
        vb_cycle();
        check("t4_pos_x", 32'(pos_x), 9);
        check("t4_owner", 32'(owner), 2);

        // 5: async reset while pending
        tick();
        req = 4'b0001; xs[0] = 5'd31;
        tick();
        req = '0;
        check("t5_pending", 32'(pending), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_pos_x", 32'(pos_x), 0);
        check("t5_rst_owner", 32'(owner), 0);
        check("t5_rst_pending", 32'(pending), 0);
        check("t5_rst_commit", 32'(commit), 0);
        tick();
        reset = 1'b0;
        vb_cycle();
        check("t5_no_commit", 32'(commit), 0);
        check("t5_pos_x_kept0", 32'(pos_x), 0);
        req = 4'b1000; xs[3] = 5'd12;
        tick();
        check("t5_grant3", 32'(grant), 32'b1000);
        req = '0;
        vb_cycle();
        check("t5_owner3", 32'(owner), 3);
        check("t5_pos_x3", 32'(pos_x), 12);

        // 6: frame counter wrap
        do_reset();
        for (int v = 1; v <= 17; v++) begin
            vb_cycle();
            tick();
            if (v == 15) check("t6_fc15", 32'(frame_count), 15);
            if (v == 16) check("t6_fc16", 32'(frame_count), 0);
            if (v == 17) check("t6_fc17", 32'(frame_count), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
